// File: rtl/rf_write_arbiter.sv
// RegFile write-port arbiter: WB stage has absolute priority, MDU results are
// buffered in a small FIFO and drained into cycles where WB leaves the port idle.
module rf_write_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_reg,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [ADDR_W-1:0]      mdu_reg,
  input  logic [DATA_W-1:0]      mdu_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_wreg,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [(1<<ADDR_W)-1:0] pend_mask,
  output logic                   pipe_stall
);

  localparam int NREG = 1 << ADDR_W;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int SW   = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] r_reg  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_vld;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_starve;
  logic              r_stall;

  logic              w_wb_act;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic [SW-1:0]     w_starve_nxt;
  logic [NREG-1:0]   w_pend;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign w_wb_act  = wb_we && (wb_reg != '0);
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_wb_act && !w_empty;
  assign mdu_ready = (r_count < CW'(FIFO_DEPTH));
  // r0 results are accepted to unblock the MDU but never occupy a slot
  assign w_push    = mdu_valid && mdu_ready && (mdu_reg != '0);

  always_comb begin
    rf_we    = 1'b0;
    rf_wreg  = '0;
    rf_wdata = '0;
    if (w_wb_act) begin
      rf_we    = 1'b1;
      rf_wreg  = wb_reg;
      rf_wdata = wb_data;
    end else if (!w_empty) begin
      rf_we    = 1'b1;
      rf_wreg  = r_reg[r_head];
      rf_wdata = r_data[r_head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_pop) begin
        r_head        <= f_ptr_inc(r_head);
        r_vld[r_head] <= 1'b0;
      end
      if (w_push) begin
        r_tail        <= f_ptr_inc(r_tail);
        r_vld[r_tail] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is qualified by r_vld/r_count, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg[r_tail]  <= mdu_reg;
      r_data[r_tail] <= mdu_data;
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_vld[i]) w_pend[r_reg[i]] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end
  assign pend_mask = w_pend;

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop)
      w_starve_nxt = '0;
    else if (w_wb_act && (r_starve != SW'(STARVE_LIMIT)))
      w_starve_nxt = r_starve + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == SW'(STARVE_LIMIT));
    end
  end
  assign pipe_stall = r_stall;

endmodule
